vx_commit_arbiter: RTL
======================

Name: VX_commit_arbiter

Overview:
- Shares one commit output slot between NUM_REQS execute-unit commit streams (e.g. ALU, LSU, FPU, SFU) for a single issue slot.
- Arbitration is round-robin. A multi-beat commit (sop..eop, one beat per lane group) is never interleaved: the grant locks until its eop beat transfers.
- Sits between the execute units' commit interfaces and the per-issue-slot commit gather/writeback path.
- Output is registered, so latency is fixed at 1 cycle.

Parameters:
- NUM_REQS, 4, number of commit sources (>=1).
- DATAW, 64, flat commit payload width; bit 1 = sop, bit 0 = eop.
- LOCK_EN, 1, 1 = hold grant from first beat to eop; 0 = re-arbitrate every beat.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  per-source commit valid.
- req_data  in  NUM_REQS*DATAW  per-source payload; source i occupies [i*DATAW +: DATAW].
- req_ready  out  NUM_REQS  per-source accept.
- out_valid  out  1  registered output valid.
- out_data  out  DATAW  registered payload.
- out_sel  out  REQ_W=LOG2UP(NUM_REQS)  source index of the beat in out_data.
- out_ready  in  1  downstream accept.
- locked  out  1  a multi-beat commit is in progress.

Behaviour:
- Reset (reset=0, async): out_valid=0, out_data=0, out_sel=0, locked=0, lock_idx=0, last_grant=NUM_REQS-1. With no lock held, index 0 has first priority after reset.
- stage_ready = !out_valid | out_ready. The output stage is a pipeline register with a combinational ready back-path and no bubble, so full throughput is 1 beat/cycle.
- Grant selection (combinational):
  - If locked, grant = lock_idx, regardless of other valids.
  - Otherwise, grant = first i with req_valid[i]=1, scanning (last_grant+1) mod NUM_REQS upward with wrap-around.
  - If no valid and not locked, there is no grant.
- req_ready[i] = stage_ready & has_grant & (grant==i). All other req_ready are 0. Ready does not depend on req_valid of the granted source, except through grant selection.
- Transfer (fire) when req_valid[grant] & req_ready[grant]. Next edge:
  - out_valid=1, out_data=req_data[grant], out_sel=grant.
- If out_ready=1 with no fire, out_valid goes to 0. out_data and out_sel hold their values.
- Lock FSM, 2 states (IDLE, LOCKED):
  - IDLE -> LOCKED on fire with eop=0 and LOCK_EN=1; lock_idx<=grant.
  - LOCKED -> IDLE on fire from lock_idx with eop=1; last_grant<=lock_idx.
  - IDLE fire with eop=1: stay IDLE; last_grant<=grant.
  - LOCK_EN=0: never LOCKED; last_grant<=grant on every fire.
- locked = (state==LOCKED).
- In LOCKED, if the locked source drops valid, the arbiter idles (no grant to others) until it resumes.
- sop is not used for control. A first beat with sop=0, or a sop=1 beat while LOCKED, is a protocol error: simulation-only assertion, RTL behaviour unchanged.
- Simultaneous out_ready=1 and fire: the register is replaced in the same edge with no bubble.
- NUM_REQS=1: grant is always 0; the lock FSM still operates; out_sel is tied to 0.
- Reset asserted mid-packet: lock and pending output are dropped; sources must restart the packet.

Decomposition:
- Shared package (VX_gpu_pkg): commit sop/eop bit offsets and the REQ_W width macro.
- One natural sub-module: VX_rr_lock_arbiter. It takes valid vector, lock, lock_idx and last_grant and produces grant_onehot and grant_idx. It is combinational plus the last_grant register, and is reused by other shared-writeback arbiters.
- The output stage uses the existing elastic-buffer pipeline register, SIZE=1, registered data.

Test Plan:
- Reset priority: after reset release, req_valid=4'b1111, all single-beat (eop=1), out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles; out_valid rises 1 cycle after the first fire.
- Lock: src2 sends 3 beats (eop=0,0,1) while src0 and src1 hold valid -> out_sel=2,2,2, then 0. locked=1 for exactly the 2 cycles after beats 1 and 2; req_ready[0]=req_ready[1]=0 during the lock.
- Locked source gap: src1 beat1 (eop=0), valid low 3 cycles, then beat2 (eop=1); src3 valid throughout -> no src3 grant during the gap; src3 granted the cycle after src1's eop fire.
- Back-pressure: out_ready=0 for 4 cycles with src0 valid -> out_data held stable, req_ready=0 from the 2nd cycle. When out_ready=1, a new beat is accepted in the same cycle (no bubble).
- LOCK_EN=0: src0 and src1 both sending 2-beat packets -> beats interleave 0,1,0,1 and locked stays 0.
- Async reset mid-lock: reset=0 asserted mid-clock while locked=1 -> out_valid=0 and locked=0 immediately (no clock edge needed); after release, priority restarts at index 0.

Source files
------------

// File: rtl/vx_commit_arbiter_pkg.sv
// Shared definitions for the commit arbiter slice.
//   EOP_BIT / SOP_BIT : bit offsets of the packet markers inside a commit payload.
//   lock_state_t      : states of the packet-lock FSM.
//   log2up()          : index width for a source count, at least 1 bit.
package vx_commit_arbiter_pkg;

  localparam int EOP_BIT = 0;
  localparam int SOP_BIT = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_commit_arbiter_rr_lock.sv
// Round-robin arbiter with an external grant lock.
//   clk, reset   : clock, asynchronous active-low reset
//   valid        : per-source request vector
//   lock         : when set, lock_idx is granted unconditionally
//   lock_idx     : source holding the lock
//   update       : a grant has completed; its index becomes the new last_grant
//   grant_onehot : one-hot grant (all zero when there is no grant)
//   grant_idx    : binary grant index (0 when there is no grant)
//   has_grant    : a grant exists this cycle
module vx_commit_arbiter_rr_lock
  import vx_commit_arbiter_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int REQ_W    = log2up(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] valid,
  input  logic                lock,
  input  logic [REQ_W-1:0]    lock_idx,
  input  logic                update,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [REQ_W-1:0]    grant_idx,
  output logic                has_grant
);

  logic [REQ_W-1:0] last_grant;
  logic [REQ_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest valid source after
  // last_grant is the final (winning) assignment.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant_idx    = '0;
    has_grant    = 1'b0;
    grant_onehot = '0;
    cand         = '0;
    if (lock) begin
      grant_idx = lock_idx;
      has_grant = 1'b1;
    end else begin
      for (int off = NUM_REQS; off >= 1; off--) begin
        cand = REQ_W'((int'(last_grant) + off) % NUM_REQS);
        if (valid[cand]) begin
          grant_idx = cand;
          has_grant = 1'b1;
        end
      end
    end
    if (has_grant) grant_onehot[grant_idx] = 1'b1;
  end

  // Starting at NUM_REQS-1 gives source 0 first priority out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= REQ_W'(NUM_REQS - 1);
    end else if (update) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Commit arbiter: shares one registered commit slot among NUM_REQS sources.
// Round-robin between packets; with LOCK_EN a multi-beat packet (sop..eop)
// keeps the grant until its eop beat transfers.
//   clk, reset : clock, asynchronous active-low reset
//   req_valid  : per-source beat valid
//   req_data   : per-source payload, source i at [i*DATAW +: DATAW]
//   req_ready  : per-source accept
//   out_valid  : registered output valid
//   out_data   : registered payload (bit 1 = sop, bit 0 = eop)
//   out_sel    : source index of the beat held in out_data
//   out_ready  : downstream accept
//   locked     : a multi-beat packet is in progress
module vx_commit_arbiter
  import vx_commit_arbiter_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  parameter  int DATAW    = 64,
  parameter  int LOCK_EN  = 1,
  localparam int REQ_W    = log2up(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [REQ_W-1:0]          out_sel,
  input  logic                      out_ready,
  output logic                      locked
);

  lock_state_t         state_q, state_d;
  logic [REQ_W-1:0]    lock_idx_q;
  logic [NUM_REQS-1:0] grant_onehot;
  logic [REQ_W-1:0]    grant_idx;
  logic                has_grant;
  logic                stage_ready;
  logic                fire;
  logic                eop;
  logic [DATAW-1:0]    grant_data;

  vx_commit_arbiter_rr_lock #(
    .NUM_REQS (NUM_REQS),
    .REQ_W    (REQ_W)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .valid        (req_valid),
    .lock         (locked),
    .lock_idx     (lock_idx_q),
    .update       (fire && (eop || LOCK_EN == 0)),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .has_grant    (has_grant)
  );

  // Single-entry pipeline register: it can take a new beat whenever it is
  // empty or being drained in the same cycle, so there is no bubble.
  assign stage_ready = !out_valid || out_ready;
  assign req_ready   = (stage_ready && has_grant) ? grant_onehot : '0;
  assign grant_data  = req_data[int'(grant_idx) * DATAW +: DATAW];
  assign fire        = has_grant && stage_ready && req_valid[grant_idx];
  assign eop         = grant_data[EOP_BIT];
  assign locked      = (state_q == ST_LOCKED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fire && !eop && LOCK_EN != 0) state_d = ST_LOCKED;
      ST_LOCKED: if (fire && eop) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && state_d == ST_LOCKED) lock_idx_q <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: payload is reset too so a dropped beat never reappears as stale data.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Packet framing checks; they observe only and never alter behaviour.
  sop_on_first_beat: assert property (@(posedge clk) disable iff (!reset)
    (LOCK_EN != 0 && fire && state_q == ST_IDLE) |-> grant_data[SOP_BIT]);
  no_sop_mid_packet: assert property (@(posedge clk) disable iff (!reset)
    (fire && state_q == ST_LOCKED) |-> !grant_data[SOP_BIT]);

endmodule
